rpn_lan_tx: RTL and testbench

Reliable LAN transmitter feeding peer nodes' LAN receive stages. It takes one control message at a time from the Control module and assigns the next per-destination sequence number from a Sequence Number BRAM. It sends the message to the Network Bridge and waits for the matching ACK, retransmitting on timeout. The stored sequence number is committed only after the ACK, so it always equals the last sequence number the receiver acknowledged.

---
 rtl/rpn_lan_pkg.sv | 39 +++
 rtl/rpn_lan_ack_timer.sv | 34 +++
 rtl/rpn_lan_tx.sv | 181 ++++++++++++++++++
 tb/tb_rpn_lan_tx.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rpn_lan_pkg.sv
// Shared LAN message layout, type codes, FSM encoding and BRAM addressing for
// the reliable LAN transmitter.
package rpn_lan_pkg;

   localparam logic [7:0] RPN_MSG_TYPE_LAN_PUB = 8'h21;
   localparam logic [7:0] RPN_MSG_TYPE_LAN_ACK = 8'h22;

   localparam int MSG_TYPE_WIDTH = 8;

   // PUB_LAN packet: type | sender | seq | fwd_ctid | data, LSB first
   localparam int PUB_LAN_TYPE_OFFSET     = 0;
   localparam int PUB_LAN_SENDER_OFFSET   = 8;
   localparam int PUB_LAN_SENDER_WIDTH    = 8;
   localparam int PUB_LAN_SEQ_OFFSET      = 16;
   localparam int PUB_LAN_SEQ_WIDTH       = 32;
   localparam int PUB_LAN_FWD_CTID_OFFSET = 48;
   localparam int PUB_LAN_FWD_CTID_WIDTH  = 8;
   localparam int PUB_LAN_DATA_OFFSET     = 56;
   localparam int PUB_LAN_DATA_WIDTH      = 256;

   localparam int LAN_ACK_TYPE_OFFSET   = 0;
   localparam int LAN_ACK_SENDER_OFFSET = 8;
   localparam int LAN_ACK_SENDER_WIDTH  = 8;
   localparam int LAN_ACK_SEQ_OFFSET    = 16;
   localparam int LAN_ACK_SEQ_WIDTH     = 32;
   localparam int LAN_ACK_END           = LAN_ACK_SEQ_OFFSET + LAN_ACK_SEQ_WIDTH;

   localparam int BRAM_ADDR_SHIFT = 2;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_READ_SEQ  = 3'd1,
      ST_SEND      = 3'd2,
      ST_WAIT_ACK  = 3'd3,
      ST_WRITE_SEQ = 3'd4,
      ST_ERROR     = 3'd5
   } lan_tx_state_t;

endpackage

// File: rtl/rpn_lan_ack_timer.sv
// Loadable up-counter with synchronous clear, count enable and a terminal-count
// flag; shared by the LAN and WAN transmitters for ACK timeouts.
module rpn_lan_ack_timer #(
   parameter int WIDTH = 17
) (
   input  logic             i_clk,
   input  logic             i_ap_rst_n,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             enable,
   input  logic [WIDTH-1:0] terminal,
   output logic [WIDTH-1:0] count,
   output logic             expired
);

   // clear has priority over load, load over counting
   always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
      if (!i_ap_rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (enable) begin
         count <= count + WIDTH'(1);
      end else begin
         count <= count;
      end
   end

   assign expired = (count == terminal);

endmodule

// File: rtl/rpn_lan_tx.sv
// Reliable LAN transmitter: stamps each control message with the next
// per-destination sequence number, retransmits until ACKed, then commits it.
module rpn_lan_tx
   import rpn_lan_pkg::*;
#(
   parameter int AXIS_DATA_WIDTH           = 512,
   parameter int AXIS_KEEP_WIDTH           = 64,
   parameter int NODE_ID_WIDTH             = 8,
   parameter int CLUSTER_ID_WIDTH          = 8,
   parameter int LAN_SEQUENCE_NUMBER_WIDTH = 32,
   parameter int PUB_LAN_DATA_WIDTH        = 256,
   parameter int BRAM_ADDR_WIDTH           = 32,
   parameter int TIMEOUT_CYCLES            = 100000,
   parameter int MAX_RETRIES               = 7
) (
   input  logic                                 i_clk,
   input  logic                                 i_ap_rst_n,
   input  logic [NODE_ID_WIDTH-1:0]             i_node_id,
   input  logic                                 from_ctrl_tvalid,
   output logic                                 from_ctrl_tready,
   input  logic [PUB_LAN_DATA_WIDTH-1:0]        from_ctrl_tdata,
   input  logic [NODE_ID_WIDTH-1:0]             from_ctrl_tdest,
   input  logic [CLUSTER_ID_WIDTH-1:0]          from_ctrl_tuser,
   output logic                                 to_nb_tvalid,
   input  logic                                 to_nb_tready,
   output logic [AXIS_DATA_WIDTH-1:0]           to_nb_tdata,
   output logic [AXIS_KEEP_WIDTH-1:0]           to_nb_tkeep,
   output logic [NODE_ID_WIDTH-1:0]             to_nb_tdest,
   output logic                                 to_nb_tlast,
   input  logic                                 from_ack_tvalid,
   output logic                                 from_ack_tready,
   input  logic [AXIS_DATA_WIDTH-1:0]           from_ack_tdata,
   output logic                                 to_seq_BRAM_CLK,
   output logic                                 to_seq_BRAM_RST,
   output logic                                 to_seq_BRAM_EN,
   output logic [3:0]                           to_seq_BRAM_WEN,
   output logic [BRAM_ADDR_WIDTH-1:0]           to_seq_BRAM_ADDR,
   output logic [LAN_SEQUENCE_NUMBER_WIDTH-1:0] to_seq_BRAM_DIN,
   input  logic [LAN_SEQUENCE_NUMBER_WIDTH-1:0] to_seq_BRAM_DOUT,
   output logic                                 o_tx_error,
   output logic [NODE_ID_WIDTH-1:0]             o_tx_error_node
);

   localparam int TIMER_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
   localparam int RETRY_WIDTH = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

   lan_tx_state_t state, next_state;

   logic [PUB_LAN_DATA_WIDTH-1:0]        msg_data;
   logic [NODE_ID_WIDTH-1:0]             msg_dest;
   logic [CLUSTER_ID_WIDTH-1:0]          msg_ctid;
   logic [LAN_SEQUENCE_NUMBER_WIDTH-1:0] seq;
   logic [RETRY_WIDTH-1:0]               retry_cnt;
   logic [NODE_ID_WIDTH-1:0]             err_node;
   logic [NODE_ID_WIDTH-1:0]             bram_node;
   logic [TIMER_WIDTH-1:0]               unused_timer_count;
   logic                                 timer_expired;
   logic                                 ack_match;
   logic                                 retries_left;
   logic                                 unused_ack_bits;
   logic [AXIS_DATA_WIDTH-1:0]           pkt;

   assign ack_match = from_ack_tvalid
      && (from_ack_tdata[LAN_ACK_TYPE_OFFSET +: MSG_TYPE_WIDTH] == RPN_MSG_TYPE_LAN_ACK)
      && (from_ack_tdata[LAN_ACK_SENDER_OFFSET +: NODE_ID_WIDTH] == msg_dest)
      && (from_ack_tdata[LAN_ACK_SEQ_OFFSET +: LAN_SEQUENCE_NUMBER_WIDTH] == seq);
   assign unused_ack_bits = ^from_ack_tdata[AXIS_DATA_WIDTH-1:LAN_ACK_END];
   assign retries_left    = (retry_cnt < RETRY_WIDTH'(MAX_RETRIES));

   rpn_lan_ack_timer #(
      .WIDTH (TIMER_WIDTH)
   ) u_ack_timer (
      .i_clk      (i_clk),
      .i_ap_rst_n (i_ap_rst_n),
      .clear      (state == ST_SEND && to_nb_tready),
      .load       (1'b0),
      .load_value ({TIMER_WIDTH{1'b0}}),
      .enable     (state == ST_WAIT_ACK),
      .terminal   (TIMER_WIDTH'(TIMEOUT_CYCLES - 1)),
      .count      (unused_timer_count),
      .expired    (timer_expired)
   );

   always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
      if (!i_ap_rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // A matching ACK takes priority over a timeout in the same cycle
   always_comb begin
      next_state       = state;
      from_ctrl_tready = 1'b0;
      to_nb_tvalid     = 1'b0;
      to_seq_BRAM_EN   = 1'b0;
      to_seq_BRAM_WEN  = 4'h0;
      bram_node        = msg_dest;
      o_tx_error       = 1'b0;
      case (state)
         ST_IDLE: begin
            from_ctrl_tready = 1'b1;
            to_seq_BRAM_EN   = from_ctrl_tvalid;
            bram_node        = from_ctrl_tdest;
            if (from_ctrl_tvalid) next_state = ST_READ_SEQ;
            else                  next_state = ST_IDLE;
         end
         ST_READ_SEQ: next_state = ST_SEND;
         ST_SEND: begin
            to_nb_tvalid = 1'b1;
            if (to_nb_tready) next_state = ST_WAIT_ACK;
            else              next_state = ST_SEND;
         end
         ST_WAIT_ACK: begin
            if (ack_match)          next_state = ST_WRITE_SEQ;
            else if (!timer_expired) next_state = ST_WAIT_ACK;
            else if (retries_left)  next_state = ST_SEND;
            else                    next_state = ST_ERROR;
         end
         ST_WRITE_SEQ: begin
            to_seq_BRAM_EN  = 1'b1;
            to_seq_BRAM_WEN = 4'hF;
            next_state      = ST_IDLE;
         end
         ST_ERROR: begin
            o_tx_error = 1'b1;
            next_state = ST_IDLE;
         end
         default: next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
      if (!i_ap_rst_n) begin
         msg_data  <= '0;
         msg_dest  <= '0;
         msg_ctid  <= '0;
         seq       <= '0;
         retry_cnt <= '0;
         err_node  <= '0;
      end else begin
         if (state == ST_IDLE && from_ctrl_tvalid) begin
            msg_data <= from_ctrl_tdata;
            msg_dest <= from_ctrl_tdest;
            msg_ctid <= from_ctrl_tuser;
         end
         if (state == ST_READ_SEQ) begin
            seq       <= to_seq_BRAM_DOUT + LAN_SEQUENCE_NUMBER_WIDTH'(1);
            retry_cnt <= '0;
         end
         if (state == ST_WAIT_ACK && next_state == ST_SEND) begin
            retry_cnt <= retry_cnt + RETRY_WIDTH'(1);
         end
         if (state == ST_WAIT_ACK && next_state == ST_ERROR) begin
            err_node <= msg_dest;
         end
      end
   end

   always_comb begin
      pkt = '0;
      pkt[PUB_LAN_TYPE_OFFSET +: MSG_TYPE_WIDTH]                 = RPN_MSG_TYPE_LAN_PUB;
      pkt[PUB_LAN_SENDER_OFFSET +: NODE_ID_WIDTH]                = i_node_id;
      pkt[PUB_LAN_SEQ_OFFSET +: LAN_SEQUENCE_NUMBER_WIDTH]       = seq;
      pkt[PUB_LAN_FWD_CTID_OFFSET +: CLUSTER_ID_WIDTH]           = msg_ctid;
      pkt[PUB_LAN_DATA_OFFSET +: PUB_LAN_DATA_WIDTH]             = msg_data;
   end

   assign to_nb_tdata      = pkt;
   assign to_nb_tkeep      = {AXIS_KEEP_WIDTH{1'b1}};
   assign to_nb_tdest      = msg_dest;
   assign to_nb_tlast      = 1'b1;
   assign from_ack_tready  = 1'b1;
   assign to_seq_BRAM_CLK  = i_clk;
   assign to_seq_BRAM_RST  = ~i_ap_rst_n;
   assign to_seq_BRAM_ADDR = BRAM_ADDR_WIDTH'(bram_node) << BRAM_ADDR_SHIFT;
   assign to_seq_BRAM_DIN  = seq;
   assign o_tx_error_node  = err_node;

endmodule

// File: tb/tb_rpn_lan_tx.sv
// Directed bench for rpn_lan_tx: vector table for the normal send/ACK path,
// plus sequences for timeout, dropped ACKs, expiry race, stall and reset.
module tb_rpn_lan_tx;
   import rpn_lan_pkg::*;

   localparam int DW = 512, KW = 64, NW = 8, CW = 8, SW = 32, PW = 256, AW = 32;
   localparam int TO = 16, MR = 2;
   localparam logic [NW-1:0] NODE = 8'h2A;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n = 1'b0;
   logic          ctrl_tvalid = 1'b0, ctrl_tready;
   logic [PW-1:0] ctrl_tdata = '0;
   logic [NW-1:0] ctrl_tdest = '0;
   logic [CW-1:0] ctrl_tuser = '0;
   logic          nb_tvalid, nb_tready = 1'b1, nb_tlast;
   logic [DW-1:0] nb_tdata;
   logic [KW-1:0] nb_tkeep;
   logic [NW-1:0] nb_tdest;
   logic          ack_tvalid = 1'b0, ack_tready;
   logic [DW-1:0] ack_tdata = '0;
   logic          bram_clk, bram_rst, bram_en;
   logic [3:0]    bram_wen;
   logic [AW-1:0] bram_addr;
   logic [SW-1:0] bram_din, bram_dout;
   logic          tx_error;
   logic [NW-1:0] tx_error_node;

   rpn_lan_tx #(
      .AXIS_DATA_WIDTH(DW), .AXIS_KEEP_WIDTH(KW), .NODE_ID_WIDTH(NW),
      .CLUSTER_ID_WIDTH(CW), .LAN_SEQUENCE_NUMBER_WIDTH(SW),
      .PUB_LAN_DATA_WIDTH(PW), .BRAM_ADDR_WIDTH(AW),
      .TIMEOUT_CYCLES(TO), .MAX_RETRIES(MR)
   ) dut (
      .i_clk(clk), .i_ap_rst_n(rst_n), .i_node_id(NODE),
      .from_ctrl_tvalid(ctrl_tvalid), .from_ctrl_tready(ctrl_tready),
      .from_ctrl_tdata(ctrl_tdata), .from_ctrl_tdest(ctrl_tdest), .from_ctrl_tuser(ctrl_tuser),
      .to_nb_tvalid(nb_tvalid), .to_nb_tready(nb_tready), .to_nb_tdata(nb_tdata),
      .to_nb_tkeep(nb_tkeep), .to_nb_tdest(nb_tdest), .to_nb_tlast(nb_tlast),
      .from_ack_tvalid(ack_tvalid), .from_ack_tready(ack_tready), .from_ack_tdata(ack_tdata),
      .to_seq_BRAM_CLK(bram_clk), .to_seq_BRAM_RST(bram_rst), .to_seq_BRAM_EN(bram_en),
      .to_seq_BRAM_WEN(bram_wen), .to_seq_BRAM_ADDR(bram_addr),
      .to_seq_BRAM_DIN(bram_din), .to_seq_BRAM_DOUT(bram_dout),
      .o_tx_error(tx_error), .o_tx_error_node(tx_error_node)
   );

   // BRAM model, packet/error monitor and cycle counter
   logic [SW-1:0] bram [0:255];
   logic          pre_we = 1'b0;
   logic [7:0]    pre_idx = '0;
   logic [SW-1:0] pre_val = '0;
   int            cyc = 0, wr_cnt = 0, err_cnt = 0, hs_cyc = 0;
   logic [NW-1:0] err_node_seen = '0;
   logic [DW-1:0] pkt_q [$];
   logic [NW-1:0] pdest_q [$];
   int            pcyc_q [$];
   int            n_chk = 0, n_fail = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (pre_we) bram[pre_idx] <= pre_val;
      if (bram_en) begin
         if (bram_wen != 4'h0) begin
            bram[bram_addr[9:2]] <= bram_din;
            wr_cnt <= wr_cnt + 1;
         end
         bram_dout <= bram[bram_addr[9:2]];
      end
      if (nb_tvalid && nb_tready) begin
         pkt_q.push_back(nb_tdata);
         pdest_q.push_back(nb_tdest);
         pcyc_q.push_back(cyc);
      end
      if (ctrl_tvalid && ctrl_tready) hs_cyc <= cyc;
      if (tx_error) begin
         err_cnt <= err_cnt + 1;
         err_node_seen <= tx_error_node;
      end
   end

   typedef struct {
      logic [NW-1:0] dest;
      logic [CW-1:0] ctid;
      logic [SW-1:0] init;
      logic [PW-1:0] data;
      logic [SW-1:0] exp_seq;
   } vec_t;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] mk_pkt(input logic [SW-1:0] s, input logic [CW-1:0] c,
                                            input logic [PW-1:0] d);
      logic [DW-1:0] p;
      p = '0;
      p[PUB_LAN_TYPE_OFFSET +: 8]      = RPN_MSG_TYPE_LAN_PUB;
      p[PUB_LAN_SENDER_OFFSET +: NW]   = NODE;
      p[PUB_LAN_SEQ_OFFSET +: SW]      = s;
      p[PUB_LAN_FWD_CTID_OFFSET +: CW] = c;
      p[PUB_LAN_DATA_OFFSET +: PW]     = d;
      return p;
   endfunction

   // All tasks start and end on a falling edge
   task automatic set_bram(input logic [7:0] idx, input logic [SW-1:0] val);
      pre_idx = idx; pre_val = val; pre_we = 1'b1;
      @(negedge clk);
      pre_we = 1'b0;
   endtask

   task automatic send_msg(input logic [NW-1:0] d, input logic [CW-1:0] c, input logic [PW-1:0] p);
      ctrl_tdest = d; ctrl_tuser = c; ctrl_tdata = p; ctrl_tvalid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         if (ctrl_tready) break;
         @(negedge clk);
      end
      chk("ctrl_accept", ctrl_tready, 1);
      @(negedge clk);
      ctrl_tvalid = 1'b0;
   endtask

   task automatic send_ack(input logic [NW-1:0] s, input logic [SW-1:0] q, input logic [7:0] t);
      ack_tdata = '0;
      ack_tdata[LAN_ACK_TYPE_OFFSET +: 8]    = t;
      ack_tdata[LAN_ACK_SENDER_OFFSET +: NW] = s;
      ack_tdata[LAN_ACK_SEQ_OFFSET +: SW]    = q;
      ack_tvalid = 1'b1;
      @(negedge clk);
      ack_tvalid = 1'b0;
   endtask

   task automatic wait_pkts(input int n, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (pkt_q.size() >= n) break;
         @(negedge clk);
      end
      chk("pkt_count", pkt_q.size(), n);
   endtask

   vec_t vecs [4];
   int   base, wr_base, err_base;
   logic [DW-1:0] exp_pkt;

   initial begin
      vecs[0] = '{dest: 8'd3,   ctid: 8'h00, init: 32'd5,          data: {8{32'hA5A5_0001}}, exp_seq: 32'd6};
      vecs[1] = '{dest: 8'd3,   ctid: 8'h11, init: 32'hFFFF_FFFF,  data: {8{32'h1234_5678}}, exp_seq: 32'd0};
      vecs[2] = '{dest: 8'd7,   ctid: 8'h02, init: 32'd0,          data: {4{64'hDEAD_BEEF_0BAD_F00D}}, exp_seq: 32'd1};
      vecs[3] = '{dest: 8'd200, ctid: 8'hFF, init: 32'h7FFF_FFFF,  data: {256{1'b1}}, exp_seq: 32'h8000_0000};

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_nb_tvalid", nb_tvalid, 0);
      chk("rst_ctrl_tready", ctrl_tready, 1);
      chk("rst_tx_error", tx_error, 0);
      chk("rst_bram_en", bram_en, 0);
      chk("rst_bram_wen", bram_wen, 0);
      chk("rst_bram_rst", bram_rst, 1);
      rst_n = 1'b1;
      @(negedge clk);
      chk("bram_rst_released", bram_rst, 0);
      chk("ack_tready", ack_tready, 1);

      // Table: send, immediate ACK, commit
      foreach (vecs[k]) begin
         set_bram(vecs[k].dest, vecs[k].init);
         base = pkt_q.size(); wr_base = wr_cnt;
         send_msg(vecs[k].dest, vecs[k].ctid, vecs[k].data);
         wait_pkts(base + 1, 10);
         if (pkt_q.size() > base) begin
            chk("v_pkt", pkt_q[base], mk_pkt(vecs[k].exp_seq, vecs[k].ctid, vecs[k].data));
            chk("v_tdest", pdest_q[base], vecs[k].dest);
            chk("v_latency", pcyc_q[base] - hs_cyc, 2);
         end
         chk("v_tkeep", nb_tkeep, {KW{1'b1}});
         chk("v_tlast", nb_tlast, 1);
         send_ack(vecs[k].dest, vecs[k].exp_seq, RPN_MSG_TYPE_LAN_ACK);
         chk("v_busy_after_ack", ctrl_tready, 0);
         @(negedge clk);
         chk("v_idle_2cyc", ctrl_tready, 1);
         chk("v_bram", bram[vecs[k].dest], vecs[k].exp_seq);
         chk("v_wr_cnt", wr_cnt - wr_base, 1);
         chk("v_one_pkt", pkt_q.size(), base + 1);
      end

      // No ACK: MAX_RETRIES+1 identical sends, then one error pulse
      set_bram(8'd3, 32'd5);
      base = pkt_q.size(); wr_base = wr_cnt; err_base = err_cnt;
      send_msg(8'd3, 8'h44, {8{32'hCAFE_0003}});
      wait_pkts(base + 3, 3 * (TO + 6));
      exp_pkt = mk_pkt(32'd6, 8'h44, {8{32'hCAFE_0003}});
      for (int i = 0; i < 3; i++) begin
         if (pkt_q.size() > base + i) chk("to_pkt", pkt_q[base + i], exp_pkt);
      end
      if (pkt_q.size() >= base + 3) begin
         chk("to_spacing1", pcyc_q[base + 1] - pcyc_q[base], TO + 1);
         chk("to_spacing2", pcyc_q[base + 2] - pcyc_q[base + 1], TO + 1);
      end
      for (int i = 0; i < 3 * TO; i++) begin
         if (err_cnt > err_base) break;
         @(negedge clk);
      end
      repeat (2 * TO) @(negedge clk);
      chk("to_err_pulses", err_cnt - err_base, 1);
      chk("to_err_node", err_node_seen, 3);
      chk("to_err_node_held", tx_error_node, 3);
      chk("to_bram_kept", bram[3], 5);
      chk("to_no_write", wr_cnt - wr_base, 0);
      chk("to_no_4th_send", pkt_q.size(), base + 3);
      chk("to_idle", ctrl_tready, 1);

      // Non-matching ACKs dropped; correct ACK on the second retry commits
      set_bram(8'd9, 32'd10);
      base = pkt_q.size(); wr_base = wr_cnt; err_base = err_cnt;
      send_msg(8'd9, 8'h01, {8{32'h0000_0909}});
      wait_pkts(base + 1, 10);
      send_ack(8'd9, 32'd5, RPN_MSG_TYPE_LAN_ACK);
      send_ack(8'd4, 32'd11, RPN_MSG_TYPE_LAN_ACK);
      send_ack(8'd9, 32'd11, RPN_MSG_TYPE_LAN_PUB);
      chk("drop_still_busy", ctrl_tready, 0);
      chk("drop_no_write", wr_cnt - wr_base, 0);
      wait_pkts(base + 3, 2 * (TO + 6));
      if (pkt_q.size() >= base + 2) chk("drop_spacing", pcyc_q[base + 1] - pcyc_q[base], TO + 1);
      send_ack(8'd9, 32'd11, RPN_MSG_TYPE_LAN_ACK);
      @(negedge clk);
      chk("drop_bram", bram[9], 11);
      chk("drop_idle", ctrl_tready, 1);
      repeat (2 * TO) @(negedge clk);
      chk("drop_sends", pkt_q.size(), base + 3);
      chk("drop_no_err", err_cnt - err_base, 0);

      // Matching ACK on the timer-expiry cycle wins
      set_bram(8'd20, 32'd100);
      base = pkt_q.size(); err_base = err_cnt;
      send_msg(8'd20, 8'h00, {8{32'h2020_2020}});
      wait_pkts(base + 1, 10);
      repeat (TO - 1) @(negedge clk);
      send_ack(8'd20, 32'd101, RPN_MSG_TYPE_LAN_ACK);
      @(negedge clk);
      chk("race_bram", bram[20], 101);
      repeat (2 * TO) @(negedge clk);
      chk("race_no_resend", pkt_q.size(), base + 1);
      chk("race_no_err", err_cnt - err_base, 0);

      // Back-pressure: packet held stable while stalled
      nb_tready = 1'b0;
      set_bram(8'd50, 32'h0000_1234);
      base = pkt_q.size(); wr_base = wr_cnt; err_base = err_cnt;
      send_msg(8'd50, 8'h05, {8{32'h5050_5050}});
      exp_pkt = mk_pkt(32'h0000_1235, 8'h05, {8{32'h5050_5050}});
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         if (nb_tvalid !== 1'b1 || nb_tdata !== exp_pkt) begin
            chk("stall_hold", {nb_tvalid, nb_tdata[DW-2:0]}, {1'b1, exp_pkt[DW-2:0]});
         end
         @(negedge clk);
      end
      chk("stall_tdata", nb_tdata, exp_pkt);
      nb_tready = 1'b1;
      wait_pkts(base + 1, 5);
      wait_pkts(base + 2, TO + 6);
      if (pkt_q.size() >= base + 2) chk("stall_spacing", pcyc_q[base + 1] - pcyc_q[base], TO + 1);

      // Reset while waiting for the ACK abandons the message
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("arst_nb_tvalid", nb_tvalid, 0);
      chk("arst_bram_en", bram_en, 0);
      chk("arst_bram_wen", bram_wen, 0);
      chk("arst_tx_error", tx_error, 0);
      chk("arst_idle", ctrl_tready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3 * TO) @(negedge clk);
      chk("arst_no_send", pkt_q.size(), base + 2);
      chk("arst_no_write", wr_cnt - wr_base, 0);
      chk("arst_bram_kept", bram[50], 32'h0000_1234);
      chk("arst_no_err", err_cnt - err_base, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_chk);
      $fatal(1, "watchdog expired");
   end

endmodule
